// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned OFFSET_W = 2;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_MISS  = 2'd1,
    IC_DRAIN = 2'd2
  } ic_state_e;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
  } mem_rd_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line storage: one combinational read port, one write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_W      = ADDR_W - INDEX_BITS - OFFSET_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [INST_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INST_W-1:0]     wr_data
);

  localparam int unsigned DEPTH = 2 ** INDEX_BITS;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: fetch handshake, miss FSM and
// single-outstanding word reads to the memory controller.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              Inst_en,
  input  logic [ADDR_W-1:0] Addr,
  output logic              Inst_Status_out,
  output logic [INST_W-1:0] Inst_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_data
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - OFFSET_W;

  ic_state_e         state_q, state_d;
  logic              status_q, status_d;
  logic [INST_W-1:0] inst_q, inst_d;
  mem_rd_t           mrd_q, mrd_d;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag, rd_tag;
  logic                  rd_valid, hit, fill_we;
  logic [INST_W-1:0]     rd_data;
  logic                  unused_addr_lsb;

  assign req_idx  = Addr[INDEX_BITS+OFFSET_W-1:OFFSET_W];
  assign req_tag  = Addr[ADDR_W-1:INDEX_BITS+OFFSET_W];
  assign fill_idx = mrd_q.addr[INDEX_BITS+OFFSET_W-1:OFFSET_W];
  assign fill_tag = mrd_q.addr[ADDR_W-1:INDEX_BITS+OFFSET_W];
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign unused_addr_lsb = ^Addr[OFFSET_W-1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_we),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_data  (mem_data)
  );

  // Status is a pulse by default; a low rdy_in freezes everything including it.
  always_comb begin
    state_d  = state_q;
    status_d = 1'b0;
    inst_d   = inst_q;
    mrd_d    = mrd_q;
    fill_we  = 1'b0;
    if (!rdy_in) begin
      status_d = status_q;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (Inst_en && !clear && !status_q) begin
            if (hit) begin
              status_d = 1'b1;
              inst_d   = rd_data;
            end else begin
              mrd_d.req  = 1'b1;
              mrd_d.addr = word_align(Addr);
              state_d    = IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (mem_valid) begin
            fill_we   = 1'b1;
            mrd_d.req = 1'b0;
            state_d   = IC_IDLE;
            if (!clear) begin
              status_d = 1'b1;
              inst_d   = mem_data;
            end
          end else if (clear) begin
            state_d = IC_DRAIN;
          end
        end
        IC_DRAIN: begin
          if (mem_valid) begin
            fill_we   = 1'b1;
            mrd_d.req = 1'b0;
            state_d   = IC_IDLE;
          end
        end
        default: begin
          mrd_d.req = 1'b0;
          state_d   = IC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IC_IDLE;
      status_q <= 1'b0;
      inst_q   <= '0;
      mrd_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      inst_q   <= inst_d;
      mrd_q    <= mrd_d;
    end
  end

  assign Inst_Status_out = status_q;
  assign Inst_out        = inst_q;
  assign mem_req         = mrd_q.req;
  assign mem_addr        = mrd_q.addr;

endmodule
